// File: rtl/cpu_mu0_waitreq_if.sv
// ============================================================================
// Module   : cpu_mu0_waitreq_if
// Brief    : Unified instruction/data memory bus with waitrequest stall
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cpu_mu0_waitreq_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
);
    logic [ADDR_W-1:0] address;
    logic              write;
    logic              read;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              waitrequest;

    modport master (
        output address, write, read, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, write, read, writedata,
        output readdata, waitrequest
    );
endinterface

`default_nettype wire

// File: rtl/cpu_mu0_waitreq.sv
// ============================================================================
// Module   : cpu_mu0_waitreq
// Brief    : Multi-cycle MU0 accumulator CPU on a waitrequest memory bus.
//            Define CPU_MU0_OUTPORT_EN to add the out_valid/out_data port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_mu0_waitreq #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
) (
    input  wire logic              clk,
    input  wire logic              rst,
    cpu_mu0_waitreq_if.master      bus,
    output logic                   running
`ifdef CPU_MU0_OUTPORT_EN
    ,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      out_data
`endif
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_EXEC   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    localparam logic [3:0] OP_LDA = 4'd0;
    localparam logic [3:0] OP_STO = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_JMP = 4'd4;
    localparam logic [3:0] OP_JGE = 4'd5;
    localparam logic [3:0] OP_JNE = 4'd6;
    localparam logic [3:0] OP_STP = 4'd7;
    localparam logic [3:0] OP_OUT = 4'd8;

    // Power-up value (no reset yet) is an idle, halted core.
    state_t            state_q = S_HALTED;
    state_t            state_d;
    logic              running_q = 1'b0;
    logic              running_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] instr_q, instr_d;

    logic [3:0]        opcode;
    logic [ADDR_W-1:0] operand;
    logic [ADDR_W-1:0] pc_inc;
    logic              stall;
    logic              unused_instr_bits;

    assign opcode            = instr_q[DATA_W-1 -: 4];
    assign operand           = instr_q[ADDR_W-1:0];
    assign pc_inc            = pc_q + ADDR_W'(1);
    assign unused_instr_bits = ^instr_q;
    assign bus.writedata     = acc_q;
    assign running           = running_q;
    assign stall             = (bus.read | bus.write) & bus.waitrequest;

`ifdef CPU_MU0_OUTPORT_EN
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
`endif

    // Bus requests are decoded purely from state and the latched instruction,
    // so they hold steady for the whole of a stalled access.
    always_comb begin
        bus.address = pc_q;
        bus.read    = 1'b0;
        bus.write   = 1'b0;
        case (state_q)
            S_FETCH: bus.read = 1'b1;
            S_EXEC: begin
                bus.address = operand;
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB: bus.read  = 1'b1;
                    OP_STO:                 bus.write = 1'b1;
                    default:                ;
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        running_d = running_q;
        pc_d      = pc_q;
        acc_d     = acc_q;
        instr_d   = instr_q;
`ifdef CPU_MU0_OUTPORT_EN
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
`endif
        case (state_q)
            S_FETCH: begin
                if (!stall) begin
                    instr_d = bus.readdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!stall) begin
                    state_d = S_FETCH;
                    pc_d    = pc_inc;
                    case (opcode)
                        OP_LDA: acc_d = bus.readdata;
                        OP_ADD: acc_d = acc_q + bus.readdata;
                        OP_SUB: acc_d = acc_q - bus.readdata;
                        OP_JMP: pc_d  = operand;
                        OP_JGE: if (!acc_q[DATA_W-1]) pc_d = operand;
                        OP_JNE: if (acc_q != '0)      pc_d = operand;
                        OP_STP: begin
                            pc_d      = pc_q;
                            state_d   = S_HALTED;
                            running_d = 1'b0;
                        end
`ifdef CPU_MU0_OUTPORT_EN
                        OP_OUT: begin
                            out_valid_d = 1'b1;
                            out_data_d  = acc_q;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            running_q <= 1'b1;
            pc_q      <= '0;
            acc_q     <= '0;
            instr_q   <= '0;
`ifdef CPU_MU0_OUTPORT_EN
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            running_q <= running_d;
            pc_q      <= pc_d;
            acc_q     <= acc_d;
            instr_q   <= instr_d;
`ifdef CPU_MU0_OUTPORT_EN
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cpu_mu0_waitreq.sv
// ============================================================================
// Module   : tb_cpu_mu0_waitreq
// Brief    : Directed bench for cpu_mu0_waitreq with a waitrequest memory model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_mu0_waitreq;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic running;
`ifdef CPU_MU0_OUTPORT_EN
    logic        out_valid;
    logic [15:0] out_data;
`endif

    cpu_mu0_waitreq_if #(.DATA_W(16), .ADDR_W(12)) bus ();

    cpu_mu0_waitreq #(.DATA_W(16), .ADDR_W(12)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .running   (running)
`ifdef CPU_MU0_OUTPORT_EN
        ,
        .out_valid (out_valid),
        .out_data  (out_data)
`endif
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:4095];
    int          wcnt  = 0;
    int          nwait = 0;
    int          nwr   = 0;
    int          nvec  = 0;
    int          nfail = 0;

    assign bus.readdata    = mem[bus.address];
    assign bus.waitrequest = (bus.read || bus.write) && (wcnt < nwait);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: bus status is sampled mid-cycle, memory/wait state updated after the edge.
    task automatic tick();
        logic        act, stl, wr_done;
        logic [11:0] wa;
        logic [15:0] wd;
        @(negedge clk);
        act     = bus.read || bus.write;
        stl     = bus.waitrequest;
        wr_done = bus.write && !bus.waitrequest;
        wa      = bus.address;
        wd      = bus.writedata;
        @(posedge clk);
        #1;
        if (rst) begin
            wcnt = 0;
        end else begin
            if (wr_done) begin
                mem[wa] = wd;
                nwr++;
            end
            if (act) wcnt = stl ? wcnt + 1 : 0;
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        nwr = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic run_to_halt(output int n, input bit chk_hold);
        logic [31:0] prev;
        n = 0;
        while (running && n < 400) begin
            prev = {bus.read, bus.write, bus.address, bus.writedata};
            tick();
            n++;
            if (chk_hold && wcnt > 0)
                chk("stall_hold", {bus.read, bus.write, bus.address, bus.writedata}, prev);
        end
    endtask

    task automatic load_prog1();
        clear_mem();
        mem[0]  = 16'h000A;   // LDA 10
        mem[1]  = 16'h200B;   // ADD 11
        mem[2]  = 16'h100C;   // STO 12
        mem[3]  = 16'h7000;   // STP
        mem[10] = 16'd5;
        mem[11] = 16'd7;
    endtask

    int n;
    int exp_fetch [8] = '{0, 1, 2, 3, 4, 6, 7, 8};

    initial begin
        #1;
        chk("poweron_running", {31'd0, running}, 32'd0);
        chk("poweron_bus", {30'd0, bus.read, bus.write}, 32'd0);

        // basic program, no wait states
        load_prog1();
        nwait = 0;
        do_reset();
        chk("rst_running", {31'd0, running}, 32'd1);
        chk("rst_bus", {bus.read, bus.write, 18'd0, bus.address}, {2'b10, 18'd0, 12'h000});
        run_to_halt(n, 1'b0);
        chk("p1_cycles", n, 32'd8);
        chk("p1_result", {16'd0, mem[12]}, 32'd12);
        tick();
        tick();
        chk("p1_idle", {29'd0, running, bus.read, bus.write}, 32'd0);

        // same program, 3 wait cycles per access: 7 accesses x 4 cycles + STP exec
        load_prog1();
        nwait = 3;
        do_reset();
        run_to_halt(n, 1'b1);
        chk("p2_cycles", n, 32'd29);
        chk("p2_result", {16'd0, mem[12]}, 32'd12);
        chk("p2_idle", {30'd0, bus.read, bus.write}, 32'd0);

        // conditional branches and subtraction wrap
        clear_mem();
        mem[0]  = 16'h0014;   // LDA 20  (0x8000)
        mem[1]  = 16'h501E;   // JGE 30  not taken
        mem[2]  = 16'h0015;   // LDA 21  (0)
        mem[3]  = 16'h601E;   // JNE 30  not taken
        mem[4]  = 16'h5006;   // JGE 6   taken
        mem[5]  = 16'h7000;
        mem[6]  = 16'h3016;   // SUB 22  0-1
        mem[7]  = 16'h1017;   // STO 23
        mem[8]  = 16'h7000;
        mem[30] = 16'h7000;
        mem[20] = 16'h8000;
        mem[22] = 16'h0001;
        nwait = 0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("p3_fetch%0d", i), {bus.read, 19'd0, bus.address},
                {1'b1, 19'd0, exp_fetch[i][11:0]});
            tick();
            tick();
        end
        chk("p3_halted", {31'd0, running}, 32'd0);
        chk("p3_sub_wrap", {16'd0, mem[23]}, 32'h0000FFFF);
        chk("p3_acc", {16'd0, bus.writedata}, 32'h0000FFFF);

        // pc wrap at top of address space through a NOP opcode
        clear_mem();
        mem[0]     = 16'h0005;   // LDA 5
        mem[1]     = 16'h4FFF;   // JMP 0xFFF
        mem[5]     = 16'h1234;
        mem[12'hFFF] = 16'h9ABC; // NOP
        do_reset();
        repeat (4) tick();
        chk("p4_fetch_top", {bus.read, 19'd0, bus.address}, {1'b1, 19'd0, 12'hFFF});
        repeat (2) tick();
        chk("p4_fetch_wrap", {bus.read, 19'd0, bus.address}, {1'b1, 19'd0, 12'h000});
        chk("p4_acc", {16'd0, bus.writedata}, 32'h00001234);

        // reset during a stalled STO
        clear_mem();
        mem[0] = 16'h0005;   // LDA 5
        mem[1] = 16'h1009;   // STO 9
        mem[5] = 16'h00AA;
        nwait = 0;
        do_reset();
        repeat (3) tick();
        chk("p5_sto_req", {bus.read, bus.write, 18'd0, bus.address}, {2'b01, 18'd0, 12'd9});
        nwait = 100;
        repeat (2) tick();
        chk("p5_stalled", {bus.read, bus.write, 18'd0, bus.address}, {2'b01, 18'd0, 12'd9});
        rst = 1'b1;
        tick();
        chk("p5_rst_bus", {bus.read, bus.write, 18'd0, bus.address}, {2'b10, 18'd0, 12'd0});
        chk("p5_rst_acc", {16'd0, bus.writedata}, 32'd0);
        chk("p5_rst_running", {31'd0, running}, 32'd1);
        chk("p5_no_write", {nwr[15:0], mem[9]}, 32'd0);
        rst = 1'b0;
        nwait = 0;

        // OUT instruction
        clear_mem();
        mem[0] = 16'h0005;   // LDA 5
        mem[1] = 16'h8000;   // OUT
        mem[2] = 16'h7000;   // STP
        mem[5] = 16'hFFFE;
        do_reset();
        repeat (3) tick();
`ifdef CPU_MU0_OUTPORT_EN
        chk("p6_valid_before", {31'd0, out_valid}, 32'd0);
`endif
        tick();
        chk("p6_next_fetch", {bus.read, 19'd0, bus.address}, {1'b1, 19'd0, 12'd2});
        chk("p6_acc", {16'd0, bus.writedata}, 32'h0000FFFE);
`ifdef CPU_MU0_OUTPORT_EN
        chk("p6_valid", {31'd0, out_valid}, 32'd1);
        chk("p6_data", {16'd0, out_data}, 32'h0000FFFE);
        tick();
        chk("p6_valid_after", {31'd0, out_valid}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

`default_nettype wire
